uart_receiver: RTL and testbench

Serial-to-parallel UART receiver on the `clk_3125` (3.125 MHz) domain. It is the consumer of the frame format driven by `uart_transmitter`: 1 start bit, 8 data bits MSB-first, 1 parity bit, 1 stop bit, 27 clocks per bit. It recovers each byte by mid-bit sampling, checks parity and stop bit, and presents the byte with a one-cycle completion strobe to the inference front-end.

---
 rtl/uart_receiver.sv | 153 +++++++++++++++
 tb/tb_uart_receiver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: UART frame receiver (start, 8 data bits MSB-first, parity, stop)
//
// Ports:
//   clk_3125    - system clock; all logic on its rising edge
//   rst         - synchronous active-high reset
//   rx          - asynchronous serial input, idle high
//   parity_type - 0 = even, 1 = odd; sampled at the parity sample point
//   rx_msg      - last received byte
//   rx_parity   - parity bit as received on the last frame
//   rx_complete - one-cycle strobe; outputs valid in this cycle
//   parity_err  - parity mismatch on the last frame
//   frame_err   - stop bit sampled low on the last frame
//
// Build option: define UART_RX_PARITY_CHECK_EN to build the parity checker;
// otherwise parity_err is tied low while the parity cell is still consumed.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 27,
    parameter int SAMPLE_POINT = 13
) (
    input  logic       clk_3125,
    input  logic       rst,
    input  logic       rx,
    input  logic       parity_type,
    output logic [7:0] rx_msg,
    output logic       rx_parity,
    output logic       rx_complete,
    output logic       parity_err,
    output logic       frame_err
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [4:0] SP   = 5'(SAMPLE_POINT);
    localparam logic [4:0] LAST = 5'(CLKS_PER_BIT - 1);

    logic [1:0] r_sync;
    logic [2:0] r_state;
    logic [4:0] r_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shreg;
    logic       r_par_bit;
    logic       r_armed;
    logic       w_rx_s;
    logic       w_sample;
    logic       w_cell_end;

    assign w_rx_s     = r_sync[1];
    assign w_sample   = r_cnt == SP;
    assign w_cell_end = r_cnt == LAST;

`ifdef UART_RX_PARITY_CHECK_EN
    logic r_par_err;
    logic w_par_exp;
    assign w_par_exp = parity_type ? ~^r_shreg : ^r_shreg;
`else
    logic w_unused_parity_type;
    assign w_unused_parity_type = parity_type;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk_3125) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_par_bit   <= 1'b0;
            r_armed     <= 1'b1;
            rx_msg      <= '0;
            rx_parity   <= 1'b0;
            rx_complete <= 1'b0;
            frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
            r_par_err   <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            r_sync      <= {r_sync[0], rx};
            rx_complete <= 1'b0;
            r_cnt       <= w_cell_end ? '0 : r_cnt + 5'd1;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        // the detect cycle itself counts as cell 0
                        r_state <= S_START;
                        r_cnt   <= 5'd1;
                    end
                end
                S_START: begin
                    if (w_sample && w_rx_s) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_cell_end) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (w_sample)
                        r_shreg <= {r_shreg[6:0], w_rx_s};
                    if (w_cell_end) begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7)
                            r_state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (w_sample) begin
                        r_par_bit <= w_rx_s;
`ifdef UART_RX_PARITY_CHECK_EN
                        r_par_err <= w_rx_s != w_par_exp;
`endif
                    end
                    if (w_cell_end)
                        r_state <= S_STOP;
                end
                S_STOP: begin
                    // deliver at the stop sample and skip the rest of the
                    // stop cell so back-to-back frames can resync
                    if (w_sample) begin
                        rx_msg      <= r_shreg;
                        rx_parity   <= r_par_bit;
                        frame_err   <= ~w_rx_s;
                        rx_complete <= 1'b1;
`ifdef UART_RX_PARITY_CHECK_EN
                        parity_err  <= r_par_err;
`endif
                        // a held-low line must not retrigger until it idles high
                        if (!w_rx_s)
                            r_armed <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver with randomized frames
module tb_uart_receiver;
    logic       clk_3125 = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       parity_type = 1'b0;
    logic [7:0] rx_msg;
    logic       rx_parity;
    logic       rx_complete;
    logic       parity_err;
    logic       frame_err;

    typedef struct {
        logic [7:0] msg;
        logic       par;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_receiver dut (
        .clk_3125    (clk_3125),
        .rst         (rst),
        .rx          (rx),
        .parity_type (parity_type),
        .rx_msg      (rx_msg),
        .rx_parity   (rx_parity),
        .rx_complete (rx_complete),
        .parity_err  (parity_err),
        .frame_err   (frame_err)
    );

    always #5 clk_3125 = ~clk_3125;
    always @(posedge clk_3125) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_3125);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_msg"}, int'(rx_msg), 0);
        chk({tag, "_par"}, int'(rx_parity), 0);
        chk({tag, "_complete"}, int'(rx_complete), 0);
        chk({tag, "_perr"}, int'(parity_err), 0);
        chk({tag, "_ferr"}, int'(frame_err), 0);
    endtask

    // Reference: a frame whose line falls at cycle c is delivered at c+286
    task automatic send(input logic [7:0] d, input logic ptype, input logic flip, input logic stop);
        logic        odd_ones;
        logic        p;
        logic [10:0] bits;
        exp_t        e;
        odd_ones    = ($countones(d) % 2) == 1;
        p           = (ptype ? !odd_ones : odd_ones) ^ flip;
        parity_type = ptype;
        bits        = {1'b0, d, p, stop};
        e.msg  = d;
        e.par  = p;
`ifdef UART_RX_PARITY_CHECK_EN
        e.perr = p != (ptype ? !odd_ones : odd_ones);
`else
        e.perr = 1'b0;
`endif
        e.ferr = !stop;
        e.cyc  = cyc + 286;
        q.push_back(e);
        for (int i = 10; i >= 0; i--) begin
            rx = bits[i];
            tick(27);
        end
    endtask

    always @(negedge clk_3125) begin
        if (!rst && rx_complete) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe msg=%0h at cycle %0d, none required", rx_msg, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("msg", int'(rx_msg), int'(e.msg));
                chk("rx_parity", int'(rx_parity), int'(e.par));
                chk("parity_err", int'(parity_err), int'(e.perr));
                chk("frame_err", int'(frame_err), int'(e.ferr));
                chk("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        @(posedge clk_3125);
        @(posedge clk_3125);
        #1;
        check_zero("reset");
        rst = 1'b0;
        tick(5);

        send(8'hA5, 1'b0, 1'b0, 1'b1);
        tick(3);
        send(8'h3C, 1'b1, 1'b0, 1'b1);
        send(8'hFF, 1'b1, 1'b0, 1'b1);
        tick(5);
        send(8'h81, 1'b0, 1'b1, 1'b1);
        tick(5);

        send(8'($urandom), 1'b0, 1'b0, 1'b0);
        tick(1000);
        rx = 1'b1;
        tick(10);
        send(8'h3A, 1'b1, 1'b0, 1'b1);
        tick(5);

        rx = 1'b0;
        tick(10);
        rx = 1'b1;
        tick(20);
        send(8'h55, 1'b0, 1'b0, 1'b1);
        tick(5);

        rx = 1'b0;
        tick(27);
        for (int i = 0; i < 123; i++) begin
            rx = ((i / 27) % 2) == 0;
            tick(1);
        end
        rx  = 1'b1;
        rst = 1'b1;
        tick(1);
        check_zero("midreset");
        rst = 1'b0;
        tick(10);
        send(8'h12, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            send(8'($urandom), 1'($urandom % 2), 1'(($urandom % 4) == 0), 1'b1);
            tick(int'($urandom_range(0, 20)));
        end

        for (int i = 0; i < 400 && q.size() != 0; i++)
            tick(1);
        chk("drain_pending", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
